fifo_pkt_reader: RTL and testbench
==================================

Name: fifo_pkt_reader

Overview:
- Drain side of a switch-port FIFO: issues read enables to the FIFO, absorbs its 1-cycle read latency, and presents packets byte-by-byte on an egress valid/ready interface.
- Packet format: byte0 DA, byte1 SA, byte2 LEN (payload byte count, 0..255), then LEN payload bytes.
- Marks sop/eop and counts transmitted packets; sits between fifo_top and the switch egress port.

Parameters:
- W_WIDTH, 8, byte width of FIFO data and egress data. Must be 8 because the LEN field is byte-sized.
- CNT_WIDTH, 16, width of the transmitted-packet counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO read request; read data is valid one cycle later.
- fifo_data_out  input  W_WIDTH  FIFO read data.
- port_ready  input  1  egress sink ready.
- port_valid  output  1  egress beat valid.
- port_data  output  W_WIDTH  egress byte.
- port_sop  output  1  beat is DA (first byte of packet).
- port_eop  output  1  beat is last byte of packet.
- pkt_done  output  1  one-cycle pulse when an eop beat is accepted.
- pkt_cnt  output  CNT_WIDTH  count of accepted eop beats; wraps at 2^CNT_WIDTH.

Behaviour:
- Reset (async, rst_n=0): fifo_rd_en=0, port_valid=0, port_data=0, port_sop=0, port_eop=0, pkt_done=0, pkt_cnt=0, buffer empty, inflight=0, FSM=S_DA. Release is synchronous to clk.
- Transfer: a beat transfers on a clk edge with port_valid & port_ready.
- Stability: while port_valid=1 and port_ready=0, port_data, port_sop and port_eop hold stable. port_valid never drops without a transfer.
- Read issue (combinational): fifo_rd_en = !fifo_empty && (occ + inflight - pop) < 2.
  - occ: buffer occupancy, 0..2.
  - inflight: registered copy of the previous cycle's fifo_rd_en.
  - pop: port_valid & port_ready.
  - fifo_rd_en is never asserted while fifo_empty=1.
- Capture: when inflight=1, fifo_data_out is written into the 2-entry buffer (sub-module) on that edge.
- Latency:
  - rd_en in cycle N, data captured at end of N+1, port_valid=1 in cycle N+2.
  - With port_ready=1 and the FIFO non-empty, sustained throughput is 1 beat/cycle.
- Output: head of buffer drives port_data; port_valid = (occ != 0).
- Framing FSM advances only on accepted beats:
  - S_DA: port_sop=1 -> S_SA.
  - S_SA -> S_LEN.
  - S_LEN: on accept, load remaining = port_data.
    - LEN=0: port_eop=1 on this beat, then -> S_DA.
    - otherwise -> S_PAY.
  - S_PAY: decrement remaining per accepted beat. port_eop=1 when remaining==1; on accepting that beat -> S_DA.
- Flag timing: port_sop and port_eop are combinational from the FSM state and the head byte, and qualified by port_valid.
- pkt_done / pkt_cnt: pkt_done is registered, high the cycle after the eop transfer. pkt_cnt increments on that same edge.
- FIFO empty mid-packet: port_valid deasserts (bubble). The FSM holds state and resumes framing when data arrives; no timeout.
- Simultaneous capture and pop at occ=2: cannot occur, because the read-issue rule guarantees occ + inflight <= 2.
- Simultaneous capture and pop at occ=1: occupancy stays 1 and the head advances.
- Reset mid-packet: the partial packet is discarded and framing restarts at S_DA. The producer is responsible for re-aligning FIFO contents.

Decomposition:
- Package switch_pkg holds:
  - header constants: HDR_DA_IDX=0, HDR_SA_IDX=1, HDR_LEN_IDX=2, HDR_BYTES=3;
  - FSM state enum {S_DA, S_SA, S_LEN, S_PAY}.
- Sub-module pkt_out_buf: a 2-entry skid buffer with push, pop, occ, head_data; same clk/rst_n.
- The framing FSM, read-issue logic and counters stay in fifo_pkt_reader.

Test Plan:
- FIFO preloaded 11,22,02,AA,BB with port_ready=1 -> 5 beats on consecutive cycles starting 2 cycles after the first fifo_rd_en; sop on 11, eop on BB; pkt_done pulses once; pkt_cnt=1.
- Same packet with port_ready toggling 1,0,0,1,... -> byte order preserved and data held stable while stalled; fifo_rd_en never pushes occ+inflight above 2; no lost or duplicated bytes.
- LEN=0 packet 33,44,00 -> 3 beats; sop on 33, eop on 00; next packet 55,66,01,77 framed correctly with sop on 55 and eop on 77.
- Packet written slowly (FIFO empty between every byte) -> port_valid bubbles; framing and eop correct; fifo_rd_en=0 whenever fifo_empty=1.
- 256 back-to-back packets of LEN=1 with pkt_cnt forced to CNT_WIDTH max-1 -> pkt_cnt wraps to 0 cleanly; no gaps between packets when port_ready=1.
- rst_n asserted while in S_PAY with occ=2 -> all outputs 0 immediately (async); after release, the next byte read is treated as DA with port_sop=1.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared definitions for the switch egress path: packet header layout and
// the framing state encoding used by the FIFO packet reader.
package switch_pkg;

    localparam int HDR_DA_IDX  = 0;
    localparam int HDR_SA_IDX  = 1;
    localparam int HDR_LEN_IDX = 2;
    localparam int HDR_BYTES   = 3;

    typedef enum logic [1:0] {
        S_DA,
        S_SA,
        S_LEN,
        S_PAY
    } frame_state_t;

endpackage

// File: rtl/pkt_out_buf.sv
// Two-entry skid buffer between the FIFO read-data register and the egress
// port; entry0 is always the head presented to the sink.
module pkt_out_buf #(
    parameter int W_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [W_WIDTH-1:0] push_data,
    input  logic               pop,
    output logic [1:0]         occ,
    output logic [W_WIDTH-1:0] head_data
);

    logic [W_WIDTH-1:0] entry0;
    logic [W_WIDTH-1:0] entry1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    // NOTE: the entries are reset (not left as plain storage) because the
    // head drives port_data, which must read 0 while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ    <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) entry0 <= push_data;
                    else             entry1 <= push_data;
                    if (occ != 2'd2) occ <= occ + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    if (occ != 2'd0) occ <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new byte lands behind the
                    // surviving entry, or becomes the head if none survives.
                    if (occ == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data = entry0;

endmodule

// File: rtl/fifo_pkt_reader.sv
// Drains a switch-port FIFO: issues reads, absorbs the one-cycle read latency
// in a skid buffer, and frames DA/SA/LEN/payload packets on a valid/ready port.
module fifo_pkt_reader
    import switch_pkg::*;
#(
    parameter int W_WIDTH   = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [W_WIDTH-1:0]   fifo_data_out,
    input  logic                 port_ready,
    output logic                 port_valid,
    output logic [W_WIDTH-1:0]   port_data,
    output logic                 port_sop,
    output logic                 port_eop,
    output logic                 pkt_done,
    output logic [CNT_WIDTH-1:0] pkt_cnt
);

    logic [1:0]         occ;
    logic [W_WIDTH-1:0] head_data;
    logic               inflight;
    logic               pop;
    logic [2:0]         pending;
    logic               eop_beat;

    frame_state_t       state;
    frame_state_t       state_nxt;
    logic [7:0]         remaining;
    logic [7:0]         remaining_nxt;

    pkt_out_buf #(.W_WIDTH(W_WIDTH)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (fifo_data_out),
        .pop       (pop),
        .occ       (occ),
        .head_data (head_data)
    );

    assign port_valid = (occ != 2'd0);
    assign port_data  = head_data;
    assign pop        = port_valid & port_ready;

    // Bytes buffered plus bytes in flight after this edge's pop; at most two
    // may be outstanding so a capture never meets a full buffer.
    assign pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    // Gated by rst_n so no read is requested while held in reset.
    assign fifo_rd_en = rst_n & ~fifo_empty & (pending < 3'd2);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        port_sop      = 1'b0;
        eop_beat      = 1'b0;
        case (state)
            S_DA: begin
                port_sop = port_valid;
                if (pop) state_nxt = S_SA;
            end
            S_SA: begin
                if (pop) state_nxt = S_LEN;
            end
            S_LEN: begin
                eop_beat = (head_data == '0);
                if (pop) begin
                    remaining_nxt = head_data[7:0];
                    state_nxt     = eop_beat ? S_DA : S_PAY;
                end
            end
            S_PAY: begin
                eop_beat = (remaining == 8'd1);
                if (pop) begin
                    remaining_nxt = remaining - 8'd1;
                    if (eop_beat) state_nxt = S_DA;
                end
            end
            default: state_nxt = S_DA;
        endcase
    end

    assign port_eop = port_valid & eop_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_DA;
            remaining <= 8'd0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            pkt_done <= 1'b0;
            pkt_cnt  <= '0;
        end else begin
            inflight <= fifo_rd_en;
            pkt_done <= pop & port_eop;
            if (pop & port_eop) pkt_cnt <= pkt_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Self-checking bench for fifo_pkt_reader: a queue-based FIFO model feeds the
// DUT, and an expected-beat queue built from the packet format checks egress.
module tb_fifo_pkt_reader;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [7:0]       fifo_data_out;
    logic             port_ready;
    logic             port_valid;
    logic [7:0]       port_data;
    logic             port_sop;
    logic             port_eop;
    logic             pkt_done;
    logic [CNT_W-1:0] pkt_cnt;

    fifo_pkt_reader #(.W_WIDTH(8), .CNT_WIDTH(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_data_out (fifo_data_out),
        .port_ready    (port_ready),
        .port_valid    (port_valid),
        .port_data     (port_data),
        .port_sop      (port_sop),
        .port_eop      (port_eop),
        .pkt_done      (pkt_done),
        .pkt_cnt       (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               n_cmp = 0;
    int               n_bad = 0;
    int               cyc = 0;
    int               first_rd = -1;
    int               outstanding = 0;
    bit               stall_prev = 0;
    bit               done_exp = 0;
    beat_t            held;
    logic [CNT_W-1:0] cnt_exp = '0;
    logic [CNT_W-1:0] cnt_mark;

    logic [7:0]       src_q[$];
    logic [7:0]       fifo_q[$];
    beat_t            exp_q[$];
    int               xfer_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue a packet for the producer and append the beats the sink must see.
    task automatic add_pkt(input logic [7:0] da, input logic [7:0] sa, input logic [7:0] len,
                           input bit fixed, input logic [7:0] p0, input logic [7:0] p1);
        beat_t      b;
        logic [7:0] pay;
        src_q.push_back(da);
        b.data = da;  b.sop = 1'b1; b.eop = 1'b0; exp_q.push_back(b);
        src_q.push_back(sa);
        b.data = sa;  b.sop = 1'b0; b.eop = 1'b0; exp_q.push_back(b);
        src_q.push_back(len);
        b.data = len; b.sop = 1'b0; b.eop = (len == 8'd0); exp_q.push_back(b);
        for (int i = 0; i < int'(len); i++) begin
            if (fixed) pay = (i == 0) ? p0 : p1;
            else       pay = 8'($urandom);
            src_q.push_back(pay);
            b.data = pay; b.sop = 1'b0; b.eop = (i == int'(len) - 1); exp_q.push_back(b);
        end
    endtask

    // One clock cycle, entered just after a falling edge with inputs driven.
    task automatic cycle();
        bit    rd;
        bit    pop;
        beat_t b;
        fifo_empty = (fifo_q.size() == 0);
        #1;
        rd  = fifo_rd_en;
        pop = port_valid && port_ready;
        if (fifo_empty) check("rd_en_while_empty", fifo_rd_en, 0);
        if (stall_prev) begin
            check("hold_valid", port_valid, 1);
            check("hold_data", port_data, held.data);
            check("hold_sop", port_sop, held.sop);
            check("hold_eop", port_eop, held.eop);
        end
        check("pkt_done", pkt_done, done_exp);
        check("pkt_cnt", pkt_cnt, cnt_exp);
        done_exp = 0;
        if (pop) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 1, 0);
            end else begin
                b = exp_q.pop_front();
                check("beat_data", port_data, b.data);
                check("beat_sop", port_sop, b.sop);
                check("beat_eop", port_eop, b.eop);
                if (b.eop) begin
                    done_exp = 1;
                    cnt_exp  = cnt_exp + 1'b1;
                end
            end
            xfer_cyc.push_back(cyc);
        end
        if (rd && first_rd < 0) first_rd = cyc;
        outstanding = outstanding + int'(rd) - int'(pop);
        check("occ_plus_inflight_le2", outstanding <= 2, 1);
        stall_prev = port_valid && !port_ready;
        held.data  = port_data;
        held.sop   = port_sop;
        held.eop   = port_eop;
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() != 0) fifo_data_out = fifo_q.pop_front();
        cyc++;
        @(negedge clk);
    endtask

    // rdy_mode: 0 always, 1 pattern 1,0,0, 2 random, other never.
    // feed_mode: 0 all at once, 1 one byte into an empty FIFO every 3rd cycle, 2 random.
    task automatic step(input int rdy_mode, input int feed_mode);
        case (rdy_mode)
            0:       port_ready = 1'b1;
            1:       port_ready = ((cyc % 3) == 0);
            2:       port_ready = 1'($urandom_range(0, 1));
            default: port_ready = 1'b0;
        endcase
        case (feed_mode)
            0: while (src_q.size() != 0) fifo_q.push_back(src_q.pop_front());
            1: if (src_q.size() != 0 && fifo_q.size() == 0 && (cyc % 3) == 0)
                   fifo_q.push_back(src_q.pop_front());
            default: if (src_q.size() != 0 && $urandom_range(0, 3) != 0)
                   fifo_q.push_back(src_q.pop_front());
        endcase
        cycle();
    endtask

    task automatic drain(input int rdy_mode, input int feed_mode, input int budget);
        int n = 0;
        while ((src_q.size() != 0 || fifo_q.size() != 0 || exp_q.size() != 0 || outstanding != 0)
               && n < budget) begin
            step(rdy_mode, feed_mode);
            n++;
        end
        check("drain_within_budget", n < budget, 1);
        step(rdy_mode, feed_mode);
        step(rdy_mode, feed_mode);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        port_ready    = 1'b0;
        fifo_data_out = 8'h00;
        fifo_empty    = 1'b1;
        rst_n         = 1'b0;
        #3;
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_valid", port_valid, 0);
        check("rst_data", port_data, 0);
        check("rst_sop", port_sop, 0);
        check("rst_eop", port_eop, 0);
        check("rst_done", pkt_done, 0);
        check("rst_cnt", pkt_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Preloaded packet, sink always ready: 5 beats back to back at N+2.
        first_rd = -1;
        xfer_cyc.delete();
        add_pkt(8'h11, 8'h22, 8'h02, 1, 8'hAA, 8'hBB);
        drain(0, 0, 50);
        check("t1_beats", xfer_cyc.size(), 5);
        for (int i = 0; i < 5 && i < xfer_cyc.size(); i++)
            check("t1_latency", xfer_cyc[i] - first_rd, 2 + i);
        check("t1_cnt", pkt_cnt, 1);

        // Same packet with the sink stalling two cycles out of three.
        xfer_cyc.delete();
        add_pkt(8'h11, 8'h22, 8'h02, 1, 8'hAA, 8'hBB);
        drain(1, 0, 100);
        check("t2_beats", xfer_cyc.size(), 5);

        // Zero-length packet followed by a one-byte packet.
        add_pkt(8'h33, 8'h44, 8'h00, 1, 8'h00, 8'h00);
        add_pkt(8'h55, 8'h66, 8'h01, 1, 8'h77, 8'h00);
        drain(0, 0, 50);

        // Producer trickles one byte at a time, leaving the FIFO empty between bytes.
        add_pkt(8'h5A, 8'hA5, 8'h03, 0, 8'h00, 8'h00);
        drain(0, 1, 200);

        // Randomised packets, sink readiness and producer rate.
        for (int p = 0; p < 25; p++)
            add_pkt(8'($urandom), 8'($urandom), 8'($urandom_range(0, 12)), 0, 8'h00, 8'h00);
        drain(2, 2, 4000);

        // 256 back-to-back LEN=1 packets wrap the 8-bit packet counter.
        cnt_mark = cnt_exp;
        xfer_cyc.delete();
        for (int p = 0; p < 256; p++)
            add_pkt(8'(p), 8'(255 - p), 8'h01, 0, 8'h00, 8'h00);
        drain(0, 0, 2000);
        check("t5_beats", xfer_cyc.size(), 1024);
        if (xfer_cyc.size() == 1024)
            check("t5_no_gaps", xfer_cyc[1023] - xfer_cyc[0], 1023);
        check("t5_wrap", pkt_cnt, cnt_mark);

        // Reset while stalled in the payload with the buffer full.
        xfer_cyc.delete();
        add_pkt(8'hC1, 8'hC2, 8'd20, 0, 8'h00, 8'h00);
        for (int n = 0; n < 40 && xfer_cyc.size() < 4; n++) step(0, 0);
        check("t6_in_payload", xfer_cyc.size(), 4);
        for (int n = 0; n < 4; n++) step(3, 0);
        check("t6_outstanding", outstanding, 2);
        #1;
        check("t6_valid_before_rst", port_valid, 1);
        check("t6_fifo_nonempty", fifo_empty, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_rd_en", fifo_rd_en, 0);
        check("t6_rst_valid", port_valid, 0);
        check("t6_rst_data", port_data, 0);
        check("t6_rst_sop", port_sop, 0);
        check("t6_rst_eop", port_eop, 0);
        check("t6_rst_done", pkt_done, 0);
        check("t6_rst_cnt", pkt_cnt, 0);
        @(negedge clk);
        fifo_q.delete();
        src_q.delete();
        exp_q.delete();
        outstanding = 0;
        stall_prev  = 0;
        done_exp    = 0;
        cnt_exp     = '0;
        add_pkt(8'hD1, 8'hD2, 8'h02, 0, 8'h00, 8'h00);
        step(0, 0);
        step(0, 0);
        rst_n = 1'b1;
        drain(0, 0, 50);
        check("t6_cnt_after", pkt_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
